// File: rtl/muxn_rr.sv
// muxn_rr: N-input, W-bit registered multiplexer with valid/ready handshakes.
// The winning channel is picked internally and buffered in one output register.
// Build option MUXN_RR_EN: defined -> round-robin arbitration with a priority
// pointer; undefined -> fixed priority (lowest valid index wins, no pointer).
module muxn_rr #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 8,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_sel,
  input  logic            out_ready
);

  logic          r_valid;
  logic [W-1:0]  r_data;
  logic [SW-1:0] r_sel;

  logic          w_load;
  logic          w_found;
  logic          w_xfer;
  logic [SW-1:0] w_gnt;
  logic [W-1:0]  w_gnt_data;
  logic          w_lo_found;
  logic [SW-1:0] w_lo_idx;

`ifdef MUXN_RR_EN
  logic [SW-1:0] r_ptr;
  logic          w_hi_found;
  logic [SW-1:0] w_hi_idx;
`endif

  // Output register may take a new word when empty or being drained.
  assign w_load = !r_valid || out_ready;
  assign w_xfer = !rst && w_load && w_found;

  // Arbitration: lowest valid index overall, and (round-robin) lowest at or above ptr.
  always_comb begin
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
`ifdef MUXN_RR_EN
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
`endif
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = SW'(i);
`ifdef MUXN_RR_EN
        if (32'(i) >= 32'(r_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = SW'(i);
        end
`endif
      end
    end
`ifdef MUXN_RR_EN
    // A hit at or above ptr beats a wrapped-around hit below it.
    w_found = w_hi_found || w_lo_found;
    w_gnt   = w_hi_found ? w_hi_idx : w_lo_idx;
`else
    w_found = w_lo_found;
    w_gnt   = w_lo_idx;
`endif
  end

  // Select the granted channel's word for the output register.
  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (w_gnt == SW'(i)) begin
        w_gnt_data = in_data[i*W +: W];
      end
    end
  end

  // One-hot ready toward the granted producer, zero when stalled or in reset.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < int'(N); i++) begin
      in_ready[i] = w_xfer && (w_gnt == SW'(i));
    end
  end

  // Output register: replace on input transfer, empty on bare output transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_gnt_data;
      r_sel   <= w_gnt;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef MUXN_RR_EN
  // Priority pointer moves one past the last winner, wrapping at N-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= (w_gnt == SW'(N - 1)) ? '0 : w_gnt + SW'(1);
    end
  end
`endif

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_muxn_rr.sv
// Directed bench for muxn_rr (N=4, W=8); expectations follow MUXN_RR_EN.
module tb_muxn_rr;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned SW = 2;
`ifdef MUXN_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;

  int checks = 0;
  int errors = 0;

  muxn_rr #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    step(); step();
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_out_sel got=%0d exp=0", out_sel); end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_rr_sweep();
    logic [1:0] g;
    logic [3:0] oh;
    in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    for (int c = 0; c < 8; c++) begin
      g  = RR ? 2'(c % 4) : 2'd0;
      oh = 4'b0001 << g;
      checks++; if (in_ready !== oh) begin errors++; $display("FAIL sweep_in_ready[%0d] got=%b exp=%b", c, in_ready, oh); end
      step();
      checks++; if (out_valid !== 1'b1 || out_sel !== g) begin errors++; $display("FAIL sweep_sel[%0d] got=%0d/v%b exp=%0d/v1", c, out_sel, out_valid, g); end
      checks++; if (out_data !== 8'(8'h11 * (g + 1))) begin errors++; $display("FAIL sweep_data[%0d] got=%h exp=%h", c, out_data, 8'(8'h11 * (g + 1))); end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] g;
    do_reset();
    in_valid = 4'b1111; out_ready = 1'b1;
    step();
    checks++; if (out_sel !== 2'd0 || out_data !== 8'h11) begin errors++; $display("FAIL bp_first got=%0d/%h exp=0/11", out_sel, out_data); end
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", c, in_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_sel !== 2'd0) begin errors++; $display("FAIL bp_hold[%0d] got=v%b %h sel%0d exp=v1 11 sel0", c, out_valid, out_data, out_sel); end
    end
    out_ready = 1'b1;
    #1;
    g = RR ? 2'd1 : 2'd0;
    checks++; if (in_ready !== (4'b0001 << g)) begin errors++; $display("FAIL bp_release_ready got=%b exp=%b", in_ready, 4'b0001 << g); end
    step();
    checks++; if (out_sel !== g || out_data !== 8'(8'h11 * (g + 1))) begin errors++; $display("FAIL bp_release_word got=%0d/%h exp=%0d/%h", out_sel, out_data, g, 8'(8'h11 * (g + 1))); end
    in_valid = 4'b0000;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_sparse_wrap();
    do_reset();
    in_valid = 4'b0100; out_ready = 1'b1;
    step();
    checks++; if (out_sel !== 2'd2 || out_data !== 8'h33) begin errors++; $display("FAIL wrap_prime got=%0d/%h exp=2/33", out_sel, out_data); end
    in_valid = 4'b0011;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL wrap_ready got=%b exp=0001", in_ready); end
    step();
    checks++; if (out_sel !== 2'd0 || out_data !== 8'h11) begin errors++; $display("FAIL wrap_word got=%0d/%h exp=0/11", out_sel, out_data); end
    checks++; if (in_ready !== (RR ? 4'b0010 : 4'b0001)) begin errors++; $display("FAIL wrap_ptr got=%b exp=%b", in_ready, RR ? 4'b0010 : 4'b0001); end
    in_valid = 4'b0000;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL idle_ready got=%b exp=0000", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 8'h11) begin errors++; $display("FAIL idle_drop got=v%b %h sel%0d exp=v0 11 sel0", out_valid, out_data, out_sel); end
  endtask

  task automatic test_fixed_priority();
    logic [1:0] g;
    do_reset();
    in_valid = 4'b1010; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      g = (RR && (c % 2 == 1)) ? 2'd3 : 2'd1;
      step();
      checks++; if (out_valid !== 1'b1 || out_sel !== g || out_data !== 8'(8'h11 * (g + 1))) begin errors++; $display("FAIL prio[%0d] got=v%b sel%0d %h exp=v1 sel%0d %h", c, out_valid, out_sel, out_data, g, 8'(8'h11 * (g + 1))); end
    end
  endtask

  task automatic test_midstream_reset();
    do_reset();
    in_valid = 4'b0100; out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_valid = 4'b1111;
    step();
    checks++; if (out_valid !== 1'b1 || out_sel !== 2'd2) begin errors++; $display("FAIL mid_held got=v%b sel%0d exp=v1 sel2", out_valid, out_sel); end
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got=%b exp=0000", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin errors++; $display("FAIL mid_rst_clear got=v%b %h sel%0d exp=v0 00 sel0", out_valid, out_data, out_sel); end
    rst = 1'b0; in_valid = 4'b0110;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL mid_first_ready got=%b exp=0010", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'h22) begin errors++; $display("FAIL mid_first_word got=v%b sel%0d %h exp=v1 sel1 22", out_valid, out_sel, out_data); end
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; out_ready = 1'b0;
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    test_reset();
    test_rr_sweep();
    test_backpressure();
    test_sparse_wrap();
    test_fixed_priority();
    test_midstream_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muxn_rr.md
# muxn_rr

Parametrised N-input, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. It replaces the fixed-select 2:1 selector with built-in arbitration: the select is generated internally, round-robin by default. A single output register buffers the winner. It sits between several producer channels and one shared consumer in the simulation datapath.

## Interface
- `N`, 4: number of input channels; legal range 2..16, and need not be a power of two.
- `W`, 8: data width per channel; legal range 1..64.
- `SW`, `$clog2(N)`: select/index width. It is derived and must not be overridden.
- `clk`  in  1: sole clock. Everything is sampled on the rising edge.
- `rst`  in  1: synchronous, active-high reset. It takes effect on the `clk` edge where it is high.
- `in_valid`  in  N: bit i high means channel i offers data.
- `in_data`  in  N*W: channel i occupies bits [i*W +: W].
- `in_ready`  out  N: one-hot or zero. Bit i high means channel i transfers this cycle.
- `out_valid`  out  1: the output register holds a word.
- `out_data`  out  W: the registered winning word.
- `out_sel`  out  SW: index of the channel that supplied `out_data`.
- `out_ready`  in  1: the consumer accepts the word.

## Operation
- Transfer rules:
  - An input transfer occurs when `in_valid[i] && in_ready[i]`.
  - An output transfer occurs when `out_valid && out_ready`.
- `load = !out_valid || out_ready`. The output register may accept a new word only when `load` is high.
- Grant:
  - When `load` is high, choose at most one channel `g` with `in_valid[g]` high, using the arbitration rule below.
  - Drive `in_ready` = one-hot(g) while `load` is high. Otherwise `in_ready` = 0.
  - `in_ready` is combinational from `in_valid`, `out_valid`, `out_ready` and the pointer. There is no combinational path from `in_data`.
- Arbitration (round-robin):
  - A pointer `ptr` (SW bits) names the highest-priority channel.
  - Search `ptr, ptr+1, …, N-1, 0, …, ptr-1` and take the first channel whose valid is high.
  - After an input transfer from channel g, set `ptr <= (g == N-1) ? 0 : g+1`.
  - `ptr` never holds a value ≥ N.
  - If there is no transfer, `ptr` holds.
- Register update on each edge:
  - Input transfer: `out_data <= in_data[g]`, `out_sel <= g`, `out_valid <= 1`.
  - Output transfer with no input transfer: `out_valid <= 0`. `out_data` and `out_sel` hold their last value.
  - Simultaneous output and input transfer: the register is replaced by the new word, giving full throughput of one word per cycle.
  - Neither transfer: the register holds.
- Stall: while `out_valid && !out_ready`, `out_data` and `out_sel` are stable and `in_ready` = 0.
- No `in_valid` high and `load` high: no grant; `out_valid` falls if the held word was taken.
- Reset:
  - Effect on the edge: `out_valid`=0, `out_data`=0, `out_sel`=0, `ptr`=0.
  - While `rst` is high, `in_ready` is forced to 0.
  - A word held in the register when reset arrives is discarded.
  - No input transfer is counted during a reset cycle.

## Timing
- Latency: a word accepted on edge k appears on `out_data`/`out_valid` immediately after edge k, so it can be consumed on edge k+1.
- Throughput: one word per cycle while `out_ready` is held high.
- The pointer update is visible to arbitration in the cycle after the transfer.
- Fairness:
  - With all N channels continuously valid and `out_ready` high, grants cycle 0,1,…,N-1,0,….
  - Each channel waits at most N-1 grants.
- Inputs are not required to hold `in_valid` while not granted. The block does not depend on producers holding their offer.

## Configuration
- `MUXN_RR_EN`:
  - Defined: round-robin arbitration as described above. This is the default in the build's define list.
  - Undefined: fixed priority. The lowest-index valid channel always wins, and `ptr` is removed from the design (it is not merely unused).
  - Both modes: ports, latency, handshake and reset behaviour are identical.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with all `in_valid`=1111 -> `in_ready`=0000, `out_valid`=0, `out_data`=0, `out_sel`=0.
- Round-robin sweep (N=4, W=8, RR on): `in_data`={0x44,0x33,0x22,0x11}, `in_valid`=1111, `out_ready`=1 for 8 cycles -> `out_sel` sequence 0,1,2,3,0,1,2,3 and `out_data` 0x11,0x22,0x33,0x44 repeating, with no bubbles.
- Backpressure:
  - Stimulus: after the first word (`out_sel`=0, 0x11), drop `out_ready` for 3 cycles.
  - Response: `out_data` stays 0x11, `in_ready`=0000 throughout.
  - On release: the next word is channel 1 (0x22) and transfers on the following edge.
- Sparse/wrap:
  - Stimulus: `ptr`=3 (after a grant to channel 2), `in_valid`=0011.
  - Response: channel 0 is granted, then `ptr`=1.
  - Then with `in_valid`=0000 and `out_ready`=1: `out_valid` drops after one cycle.
- Fixed priority (`MUXN_RR_EN` undefined): `in_valid`=1010 held for 4 cycles with `out_ready`=1 -> `out_sel`=1 every cycle and channel 3 is never granted.
- Mid-stream reset: assert `rst` while `out_valid`=1 and `out_ready`=0 -> next cycle `out_valid`=0, `ptr`=0, and the first grant after reset goes to the lowest valid index.
